// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JR   = 2'b10,
    JMP_RSV  = 2'b11
  } jump_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    HALT  = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: redirect target priority, sequential/pending select and
// target alignment check.
module fetch_next_pc (
  input  logic [31:0] pc,
  input  logic        pending,
  input  logic [31:0] pending_target,
  input  logic        valid,
  input  logic        stall,
  input  logic        ifbranch,
  input  logic [1:0]  jump,
  input  logic [31:0] addr_pcadd,
  input  logic [31:0] addr_jump,
  input  logic [31:0] data_jr,
  output logic [31:0] pc4,
  output logic [31:0] seq,
  output logic [31:0] target,
  output logic        redirect,
  output logic        misalign
);
  import fetch_stage_pkg::*;

  jump_e jtype;
  logic  want;

  assign jtype = jump_e'(jump);

  always_comb begin
    pc4    = pc + 32'd4;
    seq    = pending ? pending_target : pc4;
    target = addr_pcadd;
    want   = ifbranch;
    case (jtype)
      JMP_JR: begin
        target = data_jr;
        want   = 1'b1;
      end
      JMP_J: begin
        target = addr_jump;
        want   = 1'b1;
      end
      default: ;
    endcase
    // Only the instruction sitting in IF/ID and leaving it can redirect.
    redirect = valid & ~stall & want;
    misalign = redirect & (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request, skid buffer
// and the IF/ID pipeline register. Redirects never squash the delay slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_con_stall,
  input  logic        i_con_ifbranch,
  input  logic [1:0]  i_con_jump,
  input  logic [31:0] i_addr_pcadd,
  input  logic [31:0] i_addr_jump,
  input  logic [31:0] i_data_jr,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_data_imem,
  output logic [31:0] o_addr_pc4,
  output logic [31:0] o_data_instr,
  output logic        o_valid,
  output logic        o_err_misalign
);
  import fetch_stage_pkg::*;

  fetch_state_e state, state_next;

  logic [31:0] pc;
  logic        pending;
  logic [31:0] pending_target;
  logic [31:0] skid_pc4, skid_instr;
  logic [31:0] pc4, seq, target;
  logic        redirect, misalign;
  logic        advance;

  assign advance = ~o_valid | ~i_con_stall;

  fetch_next_pc u_next_pc (
    .pc             (pc),
    .pending        (pending),
    .pending_target (pending_target),
    .valid          (o_valid),
    .stall          (i_con_stall),
    .ifbranch       (i_con_ifbranch),
    .jump           (i_con_jump),
    .addr_pcadd     (i_addr_pcadd),
    .addr_jump      (i_addr_jump),
    .data_jr        (i_data_jr),
    .pc4            (pc4),
    .seq            (seq),
    .target         (target),
    .redirect       (redirect),
    .misalign       (misalign)
  );

  always_ff @(posedge i_clk) begin
    if (!i_nrst) state <= FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (misalign)                     state_next = HALT;
        else if (i_imem_ack && !advance)  state_next = HOLD;
      end
      HOLD: begin
        if (!i_con_stall) state_next = misalign ? HALT : FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    o_imem_req  = i_nrst & (state == FETCH);
    o_imem_addr = pc;
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      pc             <= RESET_PC;
      pending        <= 1'b0;
      pending_target <= '0;
      skid_pc4       <= '0;
      skid_instr     <= NOP_INSTR;
      o_addr_pc4     <= '0;
      o_data_instr   <= NOP_INSTR;
      o_valid        <= 1'b0;
      o_err_misalign <= 1'b0;
    end else begin
      if (misalign) o_err_misalign <= 1'b1;
      case (state)
        FETCH: begin
          if (i_imem_ack) begin
            pending <= 1'b0;
            if (advance) begin
              o_addr_pc4   <= pc4;
              o_data_instr <= i_data_imem;
              o_valid      <= 1'b1;
              pc           <= redirect ? target : seq;
            end else begin
              skid_pc4   <= pc4;
              skid_instr <= i_data_imem;
              pc         <= seq;
            end
          end else begin
            // Redirect while the delay-slot fetch is still in flight.
            if (redirect) begin
              pending        <= 1'b1;
              pending_target <= target;
            end
            if (advance) begin
              o_valid      <= 1'b0;
              o_data_instr <= NOP_INSTR;
            end
          end
        end
        HOLD: begin
          if (!i_con_stall) begin
            o_addr_pc4   <= skid_pc4;
            o_data_instr <= skid_instr;
            o_valid      <= 1'b1;
            if (redirect) pc <= target;
          end
        end
        default: begin
          if (advance) begin
            o_valid      <= 1'b0;
            o_data_instr <= NOP_INSTR;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with an OR-tagged instruction memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        nrst;
  logic        stall, ifbranch;
  logic [1:0]  jump;
  logic [31:0] pcadd, ajump, jr;
  logic        req, ack_en;
  logic [31:0] addr, pc4, instr;
  logic        valid, err;
  logic [31:0] mem_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_data = 32'hAB00_0000 | addr;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .i_clk          (clk),
    .i_nrst         (nrst),
    .i_con_stall    (stall),
    .i_con_ifbranch (ifbranch),
    .i_con_jump     (jump),
    .i_addr_pcadd   (pcadd),
    .i_addr_jump    (ajump),
    .i_data_jr      (jr),
    .o_imem_req     (req),
    .o_imem_addr    (addr),
    .i_imem_ack     (ack_en),
    .i_data_imem    (mem_data),
    .o_addr_pc4     (pc4),
    .o_data_instr   (instr),
    .o_valid        (valid),
    .o_err_misalign (err)
  );

  typedef struct {
    logic        st, br;
    logic [1:0]  jp;
    logic [31:0] pa, aj, jr;
    logic        ak;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc4, e_instr;
    logic        e_err;
  } vec_t;

  vec_t v[24];

  function automatic vec_t mk(input logic st, input logic br, input logic [1:0] jp,
                              input logic [31:0] pa, input logic [31:0] aj, input logic [31:0] jrv,
                              input logic ak, input logic rq, input logic [31:0] ad,
                              input logic vl, input logic [31:0] p4, input logic [31:0] ins,
                              input logic er);
    vec_t r;
    r.st = st; r.br = br; r.jp = jp; r.pa = pa; r.aj = aj; r.jr = jrv; r.ak = ak;
    r.e_req = rq; r.e_addr = ad; r.e_valid = vl; r.e_pc4 = p4; r.e_instr = ins; r.e_err = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; ifbranch = 1'b0; jump = 2'b00;
    pcadd = '0; ajump = '0; jr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // straight line
    v[0]  = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h0,      1,32'h4,  32'hAB000000,0);
    v[1]  = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h4,      1,32'h8,  32'hAB000004,0);
    v[2]  = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h8,      1,32'hC,  32'hAB000008,0);
    // branch: delay slot at 0xC delivered, then 0x40
    v[3]  = mk(0,1,2'd0,32'h40,32'h0,32'h0,1, 1,32'hC,     1,32'h10, 32'hAB00000C,0);
    v[4]  = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h40,     1,32'h44, 32'hAB000040,0);
    // J to 0x100 while delay-slot fetch waits 3 cycles
    v[5]  = mk(0,0,2'd1,32'h0,32'h100,32'h0,0, 1,32'h44,   0,32'h0,  32'h0,0);
    v[6]  = mk(0,0,2'd1,32'h0,32'h100,32'h0,0, 1,32'h44,   0,32'h0,  32'h0,0);
    v[7]  = mk(0,0,2'd0,32'h0,32'h0,32'h0,0, 1,32'h44,     0,32'h0,  32'h0,0);
    v[8]  = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h44,     1,32'h48, 32'hAB000044,0);
    v[9]  = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h100,    1,32'h104,32'hAB000100,0);
    // stall 4 cycles with ack landing in skid
    v[10] = mk(1,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h104,    1,32'h104,32'hAB000100,0);
    v[11] = mk(1,0,2'd0,32'h0,32'h0,32'h0,1, 0,32'h108,    1,32'h104,32'hAB000100,0);
    v[12] = mk(1,0,2'd0,32'h0,32'h0,32'h0,1, 0,32'h108,    1,32'h104,32'hAB000100,0);
    v[13] = mk(1,0,2'd0,32'h0,32'h0,32'h0,1, 0,32'h108,    1,32'h104,32'hAB000100,0);
    v[14] = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 0,32'h108,    1,32'h108,32'hAB000104,0);
    v[15] = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h108,    1,32'h10C,32'hAB000108,0);
    // JR wins over J and branch
    v[16] = mk(0,1,2'd2,32'h40,32'h100,32'h200,1, 1,32'h10C, 1,32'h110,32'hAB00010C,0);
    v[17] = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h200,    1,32'h204,32'hAB000200,0);
    // pc+4 wrap
    v[18] = mk(0,0,2'd1,32'h0,32'hFFFFFFFC,32'h0,1, 1,32'h204, 1,32'h208,32'hAB000204,0);
    v[19] = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'hFFFFFFFC, 1,32'h0,  32'hFFFFFFFC,0);
    v[20] = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 1,32'h0,      1,32'h4,  32'hAB000000,0);
    // misaligned JR target halts fetch
    v[21] = mk(0,0,2'd2,32'h0,32'h0,32'h202,1, 1,32'h4,    1,32'h8,  32'hAB000004,1);
    v[22] = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 0,32'h202,    0,32'h0,  32'h0,1);
    v[23] = mk(0,0,2'd0,32'h0,32'h0,32'h0,1, 0,32'h202,    0,32'h0,  32'h0,1);

    idle_inputs();
    nrst = 1'b0;
    ack_en = 1'b0;
    tick();
    tick();
    check("rst_req",   {31'b0, req},   32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_instr", instr,          32'h0);
    check("rst_pc4",   pc4,            32'h0);
    check("rst_err",   {31'b0, err},   32'h0);
    nrst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      stall = v[i].st; ifbranch = v[i].br; jump = v[i].jp;
      pcadd = v[i].pa; ajump = v[i].aj; jr = v[i].jr; ack_en = v[i].ak;
      #1;
      check($sformatf("v%0d_req", i),  {31'b0, req}, {31'b0, v[i].e_req});
      check($sformatf("v%0d_addr", i), addr,         v[i].e_addr);
      tick();
      check($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, v[i].e_valid});
      check($sformatf("v%0d_instr", i), instr,          v[i].e_instr);
      check($sformatf("v%0d_err", i),   {31'b0, err},   {31'b0, v[i].e_err});
      if (v[i].e_valid) check($sformatf("v%0d_pc4", i), pc4, v[i].e_pc4);
    end

    // Reset clears the halt, then reset again mid-request with a stray ack.
    idle_inputs();
    nrst = 1'b0;
    ack_en = 1'b1;
    tick();
    nrst = 1'b1;
    tick();
    tick();
    tick();
    check("rr_pc4_pre", pc4, 32'hC);
    check("rr_err_clr", {31'b0, err}, 32'h0);
    ack_en = 1'b0;
    tick();
    #1;
    check("rr_req_out",  {31'b0, req}, 32'h1);
    check("rr_addr_out", addr,         32'hC);
    nrst = 1'b0;
    ack_en = 1'b1;
    #1;
    check("rr_req_in_rst", {31'b0, req}, 32'h0);
    tick();
    check("rr_valid", {31'b0, valid}, 32'h0);
    check("rr_instr", instr,          32'h0);
    check("rr_pc4",   pc4,            32'h0);
    nrst = 1'b1;
    ack_en = 1'b0;
    #1;
    check("rr_first_req",  {31'b0, req}, 32'h1);
    check("rr_first_addr", addr,         32'h0);
    tick();
    check("rr_wait_valid", {31'b0, valid}, 32'h0);
    ack_en = 1'b1;
    tick();
    check("rr_first_valid", {31'b0, valid}, 32'h1);
    check("rr_first_pc4",   pc4,            32'h4);
    check("rr_first_instr", instr,          32'hAB000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC, issues single-outstanding requests to instruction memory, and drives the IF/ID pipeline register that feeds the decode stage (pc+4 and instruction).
- Consumes the decode stage's PC feedback (branch taken, jump type, branch/jump targets).
- Architectural branch delay slot: a redirect never squashes the instruction after the branch, it only changes the next fetch address.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID for bubbles.

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  reset; one clock, synchronous, active-low.
- i_con_stall  in  1  hazard stall; IF/ID holds its contents.
- i_con_ifbranch  in  1  branch taken (decode compare result).
- i_con_jump  in  2  00 none, 01 J/JAL, 10 JR/JALR, 11 reserved (treated as none).
- i_addr_pcadd  in  32  branch target.
- i_addr_jump  in  32  J/JAL target.
- i_data_jr  in  32  JR/JALR target (forwarded rs value).
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  32  fetch address; word aligned.
- i_imem_ack  in  1  read data valid this cycle; may arrive in the same cycle as req.
- i_data_imem  in  32  instruction word.
- o_addr_pc4  out  32  IF/ID pc+4.
- o_data_instr  out  32  IF/ID instruction.
- o_valid  out  1  IF/ID holds a real instruction.
- o_err_misalign  out  1  sticky: redirect target had [1:0] != 0.

Behaviour:
- Reset (i_nrst=0 at posedge):
  - pc=RESET_PC, state FETCH, pending=0.
  - o_valid=0, o_data_instr=NOP_INSTR, o_addr_pc4=0, o_err_misalign=0.
  - o_imem_req=0 while i_nrst=0. Reset mid-request abandons it; an ack in the reset cycle is ignored.
- advance = ~o_valid | ~i_con_stall (IF/ID can load this cycle).
- Redirect accepted only when o_valid & ~i_con_stall.
  - Target priority: jump 10 → i_data_jr; jump 01 → i_addr_jump; else i_con_ifbranch → i_addr_pcadd.
  - Redirect inputs are ignored when o_valid=0.
- seq = pending ? pending_target : pc+4.
- State FETCH: o_imem_req=1, o_imem_addr=pc (stable until ack).
  - ack & advance: IF/ID <= {pc+4, i_data_imem}, o_valid=1. pc <= redirect-now target, else seq. Clear pending.
  - ack & ~advance: skid <= {pc+4, i_data_imem}. pc <= seq. Clear pending. Go to HOLD.
  - ~ack & redirect: pending=1, pending_target=target. pc unchanged.
  - ~ack & advance: o_valid=0, o_data_instr=NOP_INSTR (bubble).
- State HOLD: o_imem_req=0.
  - When ~i_con_stall: IF/ID <= skid, o_valid=1, go to FETCH. A redirect accepted that cycle writes pc <= target directly.
- Misaligned target (target[1:0] != 0) when a redirect is accepted:
  - o_err_misalign=1, go to HALT.
  - HALT: no requests. IF/ID drains to bubble when unstalled. Exit only by reset.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 → 0).
- Throughput: 1 instr/cycle with ack tied high. Fetch latency = ack latency + 1 cycle into IF/ID.

Decomposition:
- Shared package holds:
  - jump-type enum {JMP_NONE, JMP_J, JMP_JR, JMP_RSV};
  - fetch state enum {FETCH, HOLD, HALT};
  - NOP_INSTR constant.
- One combinational sub-module, fetch_next_pc: target priority mux, seq/pending select, misalignment check.
- The PC, skid and IF/ID registers stay in fetch_stage.

Test Plan:
- Straight-line fetch:
  - Stimulus: ack tied 1, mem[i]=i.
  - Required: o_imem_addr 0,4,8…; o_valid=1 from cycle 2; o_addr_pc4 4,8,12 with matching instrs.
- Branch with delay slot:
  - Stimulus: ifbranch=1, pcadd=0x40 while IF/ID holds pc4=0x8.
  - Required: delay slot at 0x8 delivered; next addr 0x40; no NOP inserted.
- Pending redirect:
  - Stimulus: ack 3 cycles late, J to 0x100 accepted while delay-slot fetch is outstanding.
  - Required: addr held until ack; delay slot delivered; next addr 0x100; bubbles (o_valid=0, instr=0) during wait.
- Stall with skid:
  - Stimulus: stall=1 for 4 cycles while ack arrives.
  - Required: req drops after ack; IF/ID unchanged during stall; skid word appears first cycle after release; no instruction lost or duplicated.
- JR priority and misalign:
  - Stimulus: jump=10 with ifbranch=1 and jr=0x200 → fetch 0x200; then jr=0x202.
  - Required: o_err_misalign=1; no further req.
- Reset mid-request:
  - Stimulus: nrst low during outstanding req.
  - Required: o_valid=0, o_data_instr=0, first req after release at RESET_PC.
